seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 1000, is the number of clk cycles per digit slot; legal range is 4 to 65535.
REQ-002 Parameter DEAD_CYC, default 2, is the number of blanked cycles at the start of each slot; legal range is 0 to SCAN_DIV-2.
REQ-003 Parameter BLINK_FRAMES, default 64, is the number of full frames per blink half-period; legal range is 1 to 255.
REQ-004 The module SHALL have one clock and a synchronous, active-high reset, per the ports below.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port load, input, 1 bit: single-cycle request to display data_in.
REQ-008 Port data_in, input, 16 bits: four BCD digits, where digit k is data_in[4k+3:4k] and digit 0 is the rightmost.
REQ-009 Port blink_en, input, 1 bit: when 1, enables display blinking.
REQ-010 Port dec_value, output, 4 bits: value fed to the shared 7-segment decoder.
REQ-011 Port dec_en, output, 1 bit: decoder enable; 0 selects the decoder's blank pattern.
REQ-012 Port digit_sel, output, 4 bits: one-hot, active-high digit strobe; bit k drives digit k.
REQ-013 Port ack, output, 1 bit: one-cycle pulse when new data is committed to the display.

Function
REQ-014 The block SHALL hold four registered state items: slot counter cnt (0..SCAN_DIV-1), digit index idx (0..3), 16-bit shadow register, and pending flag with a 16-bit pending buffer.
REQ-015 cnt SHALL increment each cycle and wrap to 0 after SCAN_DIV-1.
- On that wrap, idx increments modulo 4 (order 0,1,2,3,0).
REQ-016 A frame boundary SHALL be the cycle with cnt==SCAN_DIV-1 and idx==3.
REQ-017 Every output except ack SHALL be a pure function of registered state, with no combinational path from any input.
REQ-018 When load=1 on a non-boundary cycle, data_in SHALL be written to the pending buffer and pending set to 1.
- A later load before the boundary overwrites the buffer; last write wins.
REQ-019 At a frame boundary, if load=1, data_in SHALL be written directly to shadow.
- Else, if pending=1, the pending buffer is written to shadow.
- In either case pending clears and ack=1 in the next cycle only.
REQ-020 If neither load nor pending is set at a frame boundary, shadow SHALL be unchanged and ack SHALL stay 0.
REQ-021 dec_value SHALL equal shadow digit idx at all times, whether or not the digit is blanked.
REQ-022 Digit idx SHALL be visible (digit_sel = 1<<idx and dec_en=1) only when all of the following hold; otherwise digit_sel=0 and dec_en=0:
- cnt >= DEAD_CYC;
- the digit value is <= 9;
- the digit is not a leading zero;
- the blink mask is off.
REQ-023 Leading-zero rule: digit k>0 SHALL be blanked when it and every higher digit are 0; digit 0 is never blanked by this rule (shadow 0x0000 shows a single "0").
REQ-024 A digit with value 10..15 SHALL be blanked and SHALL still count as nonzero for the leading-zero rule.
REQ-025 A frame counter SHALL count frame boundaries 0..BLINK_FRAMES-1 and toggle blink phase on wrap; it runs regardless of blink_en.
REQ-026 The blink mask SHALL be on when blink_en=1 and blink phase=1.
- Deasserting blink_en restores the display at the next cycle with no phase reset.

Reset
REQ-027 When rst=1 at a clock edge, all of the following SHALL clear: cnt, idx, shadow, pending buffer, pending, frame counter and blink phase.
REQ-028 In the cycle after reset: digit_sel=0000, dec_en=0, dec_value=0, ack=0.
REQ-029 rst SHALL take priority over load.
- A load coincident with rst is discarded.
- A pending update is lost when rst asserts mid-frame.
REQ-030 With DEAD_CYC>0, the first visible strobe after reset SHALL be digit 0 showing "0", at cnt==DEAD_CYC.

Verification (SCAN_DIV=8, DEAD_CYC=2, BLINK_FRAMES=2)
REQ-031 Reset release -> cycles 0-1: digit_sel=0000; cycles 2-7: digit_sel=0001, dec_value=0, dec_en=1; cycles 8-31: digit_sel=0000 (leading zeros).
REQ-032 load with data_in=0x1234 at cycle 5 after reset -> shadow unchanged until the boundary at cycle 31; ack=1 at cycle 32 only; next frame strobes 0001/4, 0010/3, 0100/2, 1000/1.
REQ-033 Two loads, 0x0042 then 0x0007, in one frame -> only 0x0007 is committed with one ack; digits 1-3 are blanked; digit 0 shows 7.
REQ-034 load 0x0A05 on a boundary cycle -> committed immediately with ack the next cycle; digit 2 is blanked (invalid), digit 3 is blanked (leading zero), digit 1 shows 0, digit 0 shows 5.
REQ-035 blink_en=1 held -> display dark for 2 frames, then lit for 2 frames, repeating; dropping blink_en mid-dark restores strobes the next cycle.
REQ-036 load at cycle 10, then rst at cycle 20 -> no ack ever; shadow=0; display shows "0" after reset.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: four-digit multiplexed 7-segment scan controller.
// Scans one digit per slot of SCAN_DIV cycles and blanks the first DEAD_CYC
// cycles of each slot to hide ghosting. Leading zeros and non-BCD digits are
// suppressed. New data is staged and committed only at a frame boundary, so a
// frame never shows a mix of old and new digits. An optional blink mask
// alternates dark/lit every BLINK_FRAMES frames.
module seg_scan_ctrl #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEAD_CYC     = 2,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic        blink_en,
    output logic [3:0]  dec_value,
    output logic        dec_en,
    output logic [3:0]  digit_sel,
    output logic        ack
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t       CNT_LAST   = cnt_t'(SCAN_DIV - 1);
    localparam cnt_t       DEAD_LIMIT = cnt_t'(DEAD_CYC);
    localparam logic [7:0] FRAME_LAST = 8'(BLINK_FRAMES - 1);

    // Registered state
    cnt_t        cnt_q,      cnt_d;
    logic [1:0]  idx_q,      idx_d;
    logic [15:0] shadow_q,   shadow_d;
    logic        pend_q,     pend_d;
    logic [15:0] pbuf_q,     pbuf_d;
    logic [7:0]  frame_q,    frame_d;
    logic        phase_q,    phase_d;
    logic        blink_q,    blink_d;
    logic        ack_q,      ack_d;

    logic        slot_end;
    logic        frame_bnd;

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_bnd = slot_end && (idx_q == 2'd3);

    // Next-state: slot/digit scan, staged data commit, blink frame counting
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        cnt_d    = slot_end ? '0 : cnt_q + cnt_t'(1);
        idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        pbuf_d   = pbuf_q;
        frame_d  = frame_q;
        phase_d  = phase_q;
        blink_d  = blink_en;
        ack_d    = 1'b0;

        if (frame_bnd) begin
            // A load on the boundary itself bypasses the buffer and wins
            if (load) begin
                shadow_d = data_in;
                ack_d    = 1'b1;
            end else if (pend_q) begin
                shadow_d = pbuf_q;
                ack_d    = 1'b1;
            end
            pend_d = 1'b0;

            if (frame_q == FRAME_LAST) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + 8'd1;
            end
        end else if (load) begin
            // Last write before the boundary wins
            pbuf_d = data_in;
            pend_d = 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (rst) begin
            // NOTE: shadow and pending buffer are plain registers, not memory, so they are reset too.
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            pbuf_q   <= '0;
            frame_q  <= '0;
            phase_q  <= 1'b0;
            blink_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            pbuf_q   <= pbuf_d;
            frame_q  <= frame_d;
            phase_q  <= phase_d;
            blink_q  <= blink_d;
            ack_q    <= ack_d;
        end
    end

    logic [3:0]  cur_digit;
    logic [15:0] upper_digits;
    logic        lead_zero;
    logic        visible;

    // Display decode: purely from registered state, never from inputs
    always_comb begin
        cur_digit    = shadow_q[{idx_q, 2'b00} +: 4];
        upper_digits = shadow_q >> {idx_q, 2'b00};
        // Digit 0 always shows, so an all-zero value reads as a single "0"
        lead_zero    = (idx_q != 2'd0) && (upper_digits == 16'h0000);
        visible      = (cnt_q >= DEAD_LIMIT)
                    && (cur_digit <= 4'd9)
                    && !lead_zero
                    && !(blink_q && phase_q);

        dec_value = cur_digit;
        dec_en    = visible;
        digit_sel = visible ? (4'b0001 << idx_q) : 4'b0000;
        ack       = ack_q;
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized scoreboard bench for seg_scan_ctrl.
// The reference model tracks time since reset and derives slot, digit, frame
// and blink phase arithmetically; only the committed value and the staged
// update are kept as model state.
module tb_seg_scan_ctrl;

    localparam int SD   = 8;
    localparam int DC   = 2;
    localparam int BF   = 2;
    localparam int NCYC = 6000;

    typedef struct packed {
        logic [3:0] sel;
        logic       en;
        logic [3:0] val;
        logic       ack;
    } out_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data_in;
    logic        blink_en;
    logic [3:0]  dec_value;
    logic        dec_en;
    logic [3:0]  digit_sel;
    logic        ack;

    seg_scan_ctrl #(
        .SCAN_DIV     (SD),
        .DEAD_CYC     (DC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .data_in   (data_in),
        .blink_en  (blink_en),
        .dec_value (dec_value),
        .dec_en    (dec_en),
        .digit_sel (digit_sel),
        .ack       (ack)
    );

    always #5 clk = ~clk;

    // Scoreboard
    out_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    // Reference model state
    int m_t      = 0;
    int m_shadow = 0;
    int m_pend   = 0;
    int m_pbuf   = 0;
    int m_ack    = 0;
    int m_be     = 0;

    function automatic bit model_boundary();
        return ((m_t % SD) == SD - 1) && (((m_t / SD) % 4) == 3);
    endfunction

    // Expected outputs for the cycle whose state the model currently holds
    function automatic out_t model_out();
        out_t o;
        int cnt   = m_t % SD;
        int idx   = (m_t / SD) % 4;
        int frame = m_t / (4 * SD);
        int phase = (frame / BF) % 2;
        int upper = m_shadow >> (4 * idx);
        int digit = upper & 15;
        bit lz    = (idx > 0) && (upper == 0);
        bit vis   = (cnt >= DC) && (digit <= 9) && !lz && !(m_be == 1 && phase == 1);
        o.sel = vis ? 4'(1 << idx) : 4'b0000;
        o.en  = vis;
        o.val = 4'(digit);
        o.ack = (m_ack != 0);
        return o;
    endfunction

    // Advance the model across one clock edge with the given inputs
    task automatic model_step(input bit r, input bit ld, input int d, input bit be);
        if (r) begin
            m_t = 0; m_shadow = 0; m_pend = 0; m_pbuf = 0; m_ack = 0; m_be = 0;
        end else begin
            if (model_boundary()) begin
                m_ack = 0;
                if (ld) begin
                    m_shadow = d; m_ack = 1;
                end else if (m_pend != 0) begin
                    m_shadow = m_pbuf; m_ack = 1;
                end
                m_pend = 0;
            end else begin
                m_ack = 0;
                if (ld) begin
                    m_pbuf = d; m_pend = 1;
                end
            end
            m_t++;
            m_be = be;
        end
    endtask

    function automatic int rand_data();
        int d = int'($urandom_range(0, 65535));
        int n = int'($urandom_range(0, 4));
        int mask = (n == 4) ? 0 : (16'hFFFF >> (4 * n));
        return d & mask;
    endfunction

    // Monitor: compare every presented output cycle against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                out_t e;
                out_t g;
                e = exp_q.pop_front();
                g = '{sel: digit_sel, en: dec_en, val: dec_value, ack: ack};
                checks++;
                if (g !== e) begin
                    fails++;
                    $display("FAIL outputs @%0t: got sel=%b en=%b val=%h ack=%b, expected sel=%b en=%b val=%h ack=%b",
                             $time, g.sel, g.en, g.val, g.ack, e.sel, e.en, e.val, e.ack);
                end
            end
        end
    end

    // Driver: issue stimulus and push expected responses
    initial begin
        bit r;
        bit ld;
        int d;
        bit be;

        rst      = 1'b1;
        load     = 1'b0;
        data_in  = '0;
        blink_en = 1'b0;
        be       = 1'b0;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            // The first edge applied reset, so the model's initial reset state applies from c=0
            if (c > 0) exp_q.push_back(model_out());

            r  = (c < 2) || ($urandom_range(0, 699) == 0);
            ld = 1'b0;
            if (c >= 40)
                ld = model_boundary() ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 24) == 0);
            d  = rand_data();
            if (c >= 100 && $urandom_range(0, 149) == 0) be = ~be;

            rst      = r;
            load     = ld;
            data_in  = 16'(d);
            blink_en = be;
            model_step(r, ld, d, be);
        end

        @(posedge clk);
        #1;
        load = 1'b0;
        @(negedge clk);
        @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
